// File: rtl/alu_path_sequencer_pkg.sv
// rtl/alu_path_sequencer_pkg.sv - shared types and opcode constants for the ALU path sequencer
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_INC = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;

  localparam int OP_MAX = 8;

  typedef struct packed {
    logic [3:0] op;
    logic       sel;
    logic       chain;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  function automatic logic op_legal(input logic [3:0] op, input int max_op);
    return int'(op) <= max_op;
  endfunction

endpackage

// File: rtl/alu_path_sequencer.sv
// rtl/alu_path_sequencer.sv - command sequencer driving the mux/register/ALU datapath
module alu_path_sequencer #(
  parameter int CNT_W  = 16,
  parameter int OP_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic             cmd_sel,
  input  logic             cmd_chain,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  output logic [7:0]       dp_inA,
  output logic [7:0]       dp_inB,
  output logic             dp_s,
  output logic [3:0]       dp_op,
  input  logic [8:0]       dp_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [8:0]       rsp_data,
  output logic             rsp_err,
  output logic [7:0]       acc,
  output logic [CNT_W-1:0] done_cnt
);
  import alu_seq_pkg::*;

  state_e           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic [8:0]       rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic [7:0]       acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          // acc cannot change before EXEC ends, so the chained operand is resolved here
          cmd_d.op    = cmd_op;
          cmd_d.sel   = cmd_sel;
          cmd_d.chain = cmd_chain;
          cmd_d.a     = cmd_chain ? acc_q : cmd_a;
          cmd_d.b     = cmd_b;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_EXEC;
      ST_EXEC: begin
        if (op_legal(cmd_q.op, OP_MAX)) begin
          rsp_data_d = dp_y;
          rsp_err_d  = 1'b0;
          acc_d      = dp_y[7:0];
        end else begin
          rsp_data_d = 9'd0;
          rsp_err_d  = 1'b1;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      rsp_data_q <= 9'd0;
      rsp_err_q  <= 1'b0;
      acc_q      <= 8'd0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
    end
  end

  // Datapath drives come straight from the command register so they hold outside LOAD
  assign dp_inA    = cmd_q.a;
  assign dp_inB    = cmd_q.b;
  assign dp_s      = cmd_q.chain | cmd_q.sel;
  assign dp_op     = cmd_q.op;
  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign acc       = acc_q;
  assign done_cnt  = cnt_q;

endmodule

// File: tb/tb_alu_path_sequencer.sv
// tb/tb_alu_path_sequencer.sv - self-checking bench for the sequencer plus a datapath model
module tb_alu_path_sequencer;
  import alu_seq_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_sel, cmd_chain;
  logic [3:0]    cmd_op;
  logic [7:0]    cmd_a, cmd_b;
  logic [7:0]    dp_inA, dp_inB;
  logic          dp_s;
  logic [3:0]    dp_op;
  logic [8:0]    dp_y;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [8:0]    rsp_data;
  logic [7:0]    acc;
  logic [CW-1:0] done_cnt;

  always #5 clk = ~clk;

  alu_path_sequencer #(.CNT_W(CW), .OP_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_sel(cmd_sel),
    .cmd_chain(cmd_chain), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .dp_inA(dp_inA), .dp_inB(dp_inB), .dp_s(dp_s), .dp_op(dp_op), .dp_y(dp_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .acc(acc), .done_cnt(done_cnt)
  );

  // Datapath model: mux into A register, B register, opcode register, combinational ALU
  logic [7:0] ra, rb;
  logic [3:0] rop;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ra <= 8'd0; rb <= 8'd0; rop <= 4'd0;
    end else begin
      ra <= dp_s ? dp_inA : dp_inB; rb <= dp_inB; rop <= dp_op;
    end
  end
  always_comb begin
    dp_y = 9'h1A5;
    case (rop)
      OP_ADD: dp_y = {1'b0, ra} + {1'b0, rb};
      OP_SUB: dp_y = {1'b0, ra} - {1'b0, rb};
      OP_AND: dp_y = {1'b0, ra & rb};
      OP_OR:  dp_y = {1'b0, ra | rb};
      OP_XOR: dp_y = {1'b0, ra ^ rb};
      OP_NOT: dp_y = {1'b0, ~ra};
      OP_INC: dp_y = {1'b0, 8'(ra + 8'd1)};
      OP_SHR: dp_y = {1'b0, ra >> 1};
      OP_SHL: dp_y = {1'b0, 8'(ra << 1)};
      default: dp_y = 9'h1A5;
    endcase
  end

  typedef struct {
    logic [3:0] op; logic sel; logic chain; logic [7:0] a; logic [7:0] b;
    logic [8:0] ed; logic ee; logic [7:0] eacc; logic [7:0] edpa; logic edps;
  } vec_t;
  typedef struct { logic [8:0] data; logic err; logic [7:0] acc; } exp_t;

  vec_t tbl [9];
  exp_t sb [$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic sel, input logic chain,
                      input logic [7:0] a, input logic [7:0] b, input logic [8:0] ed,
                      input logic ee, input logic [7:0] eacc, input logic [7:0] edpa,
                      input logic edps);
    exp_t e;
    int t;
    cmd_op = op; cmd_sel = sel; cmd_chain = chain; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    e.data = ed; e.err = ee; e.acc = eacc;
    sb.push_back(e);
    t = 0;
    while (!cmd_ready && t < 20) begin @(negedge clk); t++; end
    check("accept_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("load_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("load_dp_inA", {24'd0, dp_inA}, {24'd0, edpa});
    check("load_dp_inB", {24'd0, dp_inB}, {24'd0, b});
    check("load_dp_s", {31'd0, dp_s}, {31'd0, edps});
    check("load_dp_op", {28'd0, dp_op}, {28'd0, op});
  endtask

  task automatic collect();
    exp_t e;
    int lat;
    lat = 1;
    while (!rsp_valid && lat < 10) begin @(negedge clk); lat++; end
    check("latency", lat, 3);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("rsp_data", {23'd0, rsp_data}, {23'd0, e.data});
      check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
      check("acc", {24'd0, acc}, {24'd0, e.acc});
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (exp_cnt < (1 << CW) - 1) exp_cnt++;
    check("done_cnt", {28'd0, done_cnt}, exp_cnt);
    check("rsp_valid_after_hs", {31'd0, rsp_valid}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {23'd0, rsp_data}, 32'd0);
    check("rst_acc", {24'd0, acc}, 32'd0);
    check("rst_done_cnt", {28'd0, done_cnt}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = 4'd0; cmd_sel = 1'b0; cmd_chain = 1'b0; cmd_a = 8'd0; cmd_b = 8'd0;
    tbl[0] = '{OP_ADD, 1'b1, 1'b0, 8'hC8, 8'h64, 9'h12C, 1'b0, 8'h2C, 8'hC8, 1'b1};
    tbl[1] = '{OP_SUB, 1'b1, 1'b0, 8'h05, 8'h0A, 9'h1FB, 1'b0, 8'hFB, 8'h05, 1'b1};
    tbl[2] = '{OP_SHL, 1'b1, 1'b0, 8'h81, 8'h01, 9'h002, 1'b0, 8'h02, 8'h81, 1'b1};
    tbl[3] = '{OP_AND, 1'b1, 1'b0, 8'hF0, 8'h3C, 9'h030, 1'b0, 8'h30, 8'hF0, 1'b1};
    tbl[4] = '{OP_XOR, 1'b0, 1'b0, 8'hAA, 8'h55, 9'h000, 1'b0, 8'h00, 8'hAA, 1'b0};
    tbl[5] = '{OP_ADD, 1'b1, 1'b0, 8'h0A, 8'h14, 9'h01E, 1'b0, 8'h1E, 8'h0A, 1'b1};
    tbl[6] = '{OP_ADD, 1'b0, 1'b1, 8'hFF, 8'h05, 9'h023, 1'b0, 8'h23, 8'h1E, 1'b1};
    tbl[7] = '{4'hA,   1'b1, 1'b0, 8'h03, 8'h04, 9'h000, 1'b1, 8'h23, 8'h03, 1'b1};
    tbl[8] = '{4'hF,   1'b0, 1'b0, 8'h11, 8'h22, 9'h000, 1'b1, 8'h23, 8'h11, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_dp_inA", {24'd0, dp_inA}, 32'd0);
    check("rst_dp_s", {31'd0, dp_s}, 32'd0);
    check("rst_dp_op", {28'd0, dp_op}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    do_reset();

    for (int i = 0; i < 9; i++) begin
      send(tbl[i].op, tbl[i].sel, tbl[i].chain, tbl[i].a, tbl[i].b,
           tbl[i].ed, tbl[i].ee, tbl[i].eacc, tbl[i].edpa, tbl[i].edps);
      collect();
      handshake();
    end

    // Backpressure with a second command already waiting
    send(OP_ADD, 1'b1, 1'b0, 8'h40, 8'h01, 9'h041, 1'b0, 8'h41, 8'h40, 1'b1);
    collect();
    cmd_op = OP_ADD; cmd_sel = 1'b1; cmd_chain = 1'b0; cmd_a = 8'h02; cmd_b = 8'h03;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_data", {23'd0, rsp_data}, 32'h041);
      check("bp_rsp_err", {31'd0, rsp_err}, 32'd0);
      check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    handshake();
    check("bp_ready_after_hs", {31'd0, cmd_ready}, 32'd1);
    send(OP_ADD, 1'b1, 1'b0, 8'h02, 8'h03, 9'h005, 1'b0, 8'h05, 8'h02, 1'b1);
    collect();
    handshake();

    // Reset while in EXEC discards the operation
    do_reset();
    send(OP_ADD, 1'b1, 1'b0, 8'h01, 8'h02, 9'h003, 1'b0, 8'h03, 8'h01, 1'b1);
    @(negedge clk);
    do_reset();
    void'(sb.pop_front());

    // Reset while in RESP discards the pending response
    send(OP_ADD, 1'b1, 1'b0, 8'h07, 8'h08, 9'h00F, 1'b0, 8'h0F, 8'h07, 1'b1);
    collect();
    do_reset();
    send(OP_ADD, 1'b1, 1'b0, 8'h01, 8'h01, 9'h002, 1'b0, 8'h02, 8'h01, 1'b1);
    collect();
    handshake();

    // Counter saturation at all-ones
    for (int i = 0; i < 17; i++) begin
      send(OP_ADD, 1'b1, 1'b0, 8'(i), 8'h01, 9'(i + 1), 1'b0, 8'(i + 1), 8'(i), 1'b1);
      collect();
      handshake();
    end
    check("cnt_saturated", {28'd0, done_cnt}, 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
